aes_inv_sub_bytes_seq: RTL and testbench
========================================

Name: aes_inv_sub_bytes_seq

Overview:
- Sequencer for the AES decrypt path's InvSubBytes step.
- Accepts one 128-bit state over a valid/ready handshake.
- Pushes the 16 state bytes through LANES instantiated aes_inv_sbox lookups, LANES bytes per clock.
- Returns the substituted state over a second valid/ready handshake, so the decrypt round trades area (sbox count) against latency.

Parameters:
LANES, 4, number of aes_inv_sbox instances used in parallel; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
GROUPS, 16/LANES (derived, not overridable), number of RUN cycles per block.

Ports:
clk  input  1  single clock; all logic on rising edge.
rst  input  1  synchronous active-high reset.
clear  input  1  synchronous abort; discards any block in progress.
in_valid  input  1  in_data valid.
in_ready  output  1  block can accept a new state.
in_data  input  128  state to substitute; byte i = in_data[8i+7:8i], i = 0..15.
out_valid  output  1  out_data holds a completed result.
out_ready  input  1  consumer accepts out_data.
out_data  output  128  InvSubBytes(in_data); same byte mapping as in_data.
busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, group counter=0, captured state register=0, out_data=0, out_valid=0.
- in_ready is forced 0 while rst=1.
- rst has priority over clear; clear has priority over all handshakes.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready at an edge, capture in_data, cnt=0, go to RUN. Otherwise stay.
  - RUN: in_ready=0. Each edge, bytes cnt*LANES .. cnt*LANES+LANES-1 of the captured state feed the LANES sboxes; the results are written into the same byte positions of out_data.
    - If cnt == GROUPS-1: go to DONE and set out_valid=1.
    - Else: cnt++.
  - DONE: in_ready=0, out_valid=1. out_data and out_valid are held stable until out_valid&out_ready at an edge. Then out_valid=0 and state returns to IDLE; out_data keeps its last value.
- Latency: with the accept edge as edge 0, out_valid is first visible after edge GROUPS.
  - LANES=4: 4 edges. LANES=16: 1 edge. LANES=1: 16 edges.
- Throughput: one block per GROUPS+2 cycles when out_ready is held high. in_ready is not asserted in DONE; no overlap between blocks.
- Byte lanes not yet written in RUN are don't-care. Only out_data while out_valid=1 is specified.
- Sbox lookups are purely combinational between the capture register and the out_data write. No extra pipeline stage.
- clear=1 at an edge in any state: state=IDLE, cnt=0, out_valid=0, out_data=0. An in_valid in the same cycle is not accepted.
- clear during DONE with out_ready=1: the result is dropped, with no handshake completion.
- in_valid while not in IDLE is ignored; the upstream source must hold it.
- Counter width is clog2(GROUPS), minimum 1 bit. The counter never wraps past GROUPS-1.
- busy = (state != IDLE).
- No X may propagate on out_valid or in_ready after reset.

Test Plan:
- Known vector, LANES=4: in_data bytes 0..15 = 0x00..0x0f, out_ready=1 -> out_data bytes 0..15 = 52 09 6a d5 30 36 a5 38 bf 40 a3 9e 81 f3 d7 fb. out_valid rises exactly 4 edges after the accept edge. in_ready=0 from accept until the cycle after the out handshake.
- Fixed points, all LANES values {1,2,4,8,16}: in_data = all 0x63 -> out_data all 0x00. in_data = all 0xff -> all 0x7d. Latency = 16/LANES edges in each build.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid and out_data stay stable, in_ready stays 0, and a second in_valid is not accepted. Raising out_ready -> one handshake, then IDLE; the next block is accepted the following cycle.
- Back-to-back: 20 random states with in_valid and out_ready always 1, checked against a software inverse-sbox model -> all 20 match, in order. Block spacing = GROUPS+2 cycles.
- Abort: clear pulsed in RUN at cnt=1, and separately in DONE with out_ready=1 -> next cycle state=IDLE, out_valid=0, out_data=0, in_ready=1. No output handshake for the aborted block; the following block completes correctly.
- Reset mid-operation: rst asserted for 1 cycle in RUN -> all outputs reach reset values, in_ready=0 during the reset cycle and 1 after. Also rst and clear both high -> reset behaviour.

Source files
------------

// File: rtl/aes_inv_sub_bytes_seq.sv
// InvSubBytes sequencer: 16 state bytes go through LANES inverse sboxes, LANES bytes per clock.
// Result valid 16/LANES edges after accept; held in DONE until out_ready, no overlap between blocks.

module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  // Row-major inverse sbox; entry for input 0x00 sits in the top byte.
  localparam logic [2047:0] TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  assign y = TBL[{~a, 3'b000} +: 8];
endmodule

module aes_inv_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  localparam int GROUPS = 16 / LANES;
  localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("aes_inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic [127:0]   cap, cap_nx;
  logic [127:0]   dat_nx;
  logic           vld_nx;
  logic [7:0]     sb_in  [LANES];
  logic [7:0]     sb_out [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_inv_sbox u_sbox (.a(sb_in[l]), .y(sb_out[l]));
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      sb_in[l] = cap[8*(int'(cnt)*LANES + l) +: 8];
    end
  end

  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cap_nx   = cap;
    dat_nx   = out_data;
    vld_nx   = out_valid;
    if (clear) begin
      // Abort wins over any handshake, including a pending output in DONE.
      state_nx = IDLE;
      cnt_nx   = '0;
      vld_nx   = 1'b0;
      dat_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            cap_nx   = in_data;
            cnt_nx   = '0;
            state_nx = RUN;
          end
        end
        RUN: begin
          for (int l = 0; l < LANES; l++) begin
            dat_nx[8*(int'(cnt)*LANES + l) +: 8] = sb_out[l];
          end
          if (cnt == CW'(GROUPS - 1)) begin
            state_nx = DONE;
            vld_nx   = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            vld_nx   = 1'b0;
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cap       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      cap       <= cap_nx;
      out_data  <= dat_nx;
      out_valid <= vld_nx;
    end
  end
endmodule

// File: tb/tb_aes_inv_sub_bytes_seq.sv
// Directed bench for aes_inv_sub_bytes_seq: one instance per legal LANES value, index 2 is LANES=4.
module tb_aes_inv_sub_bytes_seq;
  logic         clk = 1'b0;
  logic         rst;
  logic         clear;
  logic         iv    [5];
  logic         irdy  [5];
  logic [127:0] idat  [5];
  logic         ov    [5];
  logic         ordy  [5];
  logic [127:0] odat  [5];
  logic         bsy   [5];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    aes_inv_sub_bytes_seq #(.LANES(1 << g)) u_dut (
      .clk(clk), .rst(rst), .clear(clear),
      .in_valid(iv[g]), .in_ready(irdy[g]), .in_data(idat[g]),
      .out_valid(ov[g]), .out_ready(ordy[g]), .out_data(odat[g]),
      .busy(bsy[g])
    );
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // Inverse sbox from first principles: inverse affine map, then GF(2^8) inverse (a^254).
  function automatic logic [7:0] inv_sbox_model(input logic [7:0] x);
    logic [7:0] a, r;
    a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_sbox_model(d[8*i +: 8]);
    return r;
  endfunction

  task automatic wait_valid(input int k, output int n);
    n = 0;
    while (!ov[k] && n < 40) begin
      step();
      n++;
    end
  endtask

  // Accept one block on instance k with out_ready high, check latency, result and return to IDLE.
  task automatic run_block(input int k, input logic [127:0] d, input logic [127:0] exp, input string tag);
    int n;
    chk({tag, "_rdy_pre"}, 128'(irdy[k]), 128'(1));
    iv[k]   = 1'b1;
    idat[k] = d;
    ordy[k] = 1'b1;
    step();
    iv[k] = 1'b0;
    chk({tag, "_rdy_acc"}, 128'(irdy[k]), 128'(0));
    wait_valid(k, n);
    chk({tag, "_lat"}, 128'(n), 128'(16 >> k));
    chk({tag, "_dat"}, odat[k], exp);
    step();
    chk({tag, "_vld_hs"}, 128'(ov[k]), 128'(0));
    chk({tag, "_rdy_hs"}, 128'(irdy[k]), 128'(1));
  endtask

  localparam logic [127:0] ALL63 = {16{8'h63}};
  localparam logic [127:0] ALLFF = {16{8'hff}};
  localparam logic [127:0] ALL7D = {16{8'h7d}};
  localparam logic [127:0] KIN   = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] KOUT  = 128'hfbd7f3819ea340bf38a53630d56a0952;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d, exp;
    logic [127:0] q[$];
    int n, sent, got, cyc, last;
    logic acc, hs;
    logic [127:0] cur;

    rst = 1'b1;
    clear = 1'b0;
    for (int k = 0; k < 5; k++) begin
      iv[k] = 1'b0; idat[k] = '0; ordy[k] = 1'b1;
    end
    step();
    step();
    chk("rst_vld", 128'(ov[2]), 128'(0));
    chk("rst_dat", odat[2], '0);
    chk("rst_busy", 128'(bsy[2]), 128'(0));
    chk("rst_rdy", 128'(irdy[2]), 128'(0));
    rst = 1'b0;
    #1;
    chk("rst_rdy_rel", 128'(irdy[2]), 128'(1));

    chk("model_known", model(KIN), KOUT);
    run_block(2, KIN, KOUT, "known");

    for (int k = 0; k < 5; k++) begin
      run_block(k, ALL63, '0, $sformatf("fix63_l%0d", 1 << k));
      run_block(k, ALLFF, ALL7D, $sformatf("fixff_l%0d", 1 << k));
    end

    // Backpressure: hold out_ready low, second in_valid must wait.
    iv[2] = 1'b1; idat[2] = KIN; ordy[2] = 1'b0;
    step();
    idat[2] = ALL63;
    wait_valid(2, n);
    chk("bp_lat", 128'(n), 128'(4));
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("bp_vld%0d", i), 128'(ov[2]), 128'(1));
      chk($sformatf("bp_dat%0d", i), odat[2], KOUT);
      chk($sformatf("bp_rdy%0d", i), 128'(irdy[2]), 128'(0));
    end
    ordy[2] = 1'b1;
    step();
    chk("bp_hs_vld", 128'(ov[2]), 128'(0));
    chk("bp_hs_rdy", 128'(irdy[2]), 128'(1));
    step();
    iv[2] = 1'b0;
    chk("bp_next_acc", 128'(bsy[2]), 128'(1));
    wait_valid(2, n);
    chk("bp_next_dat", odat[2], '0);
    step();

    // Back-to-back random blocks against the model.
    d = {$urandom, $urandom, $urandom, $urandom};
    idat[2] = d; iv[2] = 1'b1; ordy[2] = 1'b1;
    sent = 0; got = 0; cyc = 0; last = 0;
    while (got < 20 && cyc < 1000) begin
      acc = irdy[2] && iv[2];
      hs  = ov[2];
      cur = odat[2];
      step();
      cyc++;
      if (acc) begin
        q.push_back(idat[2]);
        sent++;
        if (sent < 20) idat[2] = {$urandom, $urandom, $urandom, $urandom};
        else iv[2] = 1'b0;
      end
      if (hs) begin
        exp = model(q.pop_front());
        chk($sformatf("b2b_dat%0d", got), cur, exp);
        if (got > 0) chk($sformatf("b2b_gap%0d", got), 128'(cyc - last), 128'(6));
        last = cyc;
        got++;
      end
    end
    chk("b2b_count", 128'(got), 128'(20));
    iv[2] = 1'b0;
    step();

    // Abort in RUN at cnt=1.
    iv[2] = 1'b1; idat[2] = KIN;
    step();
    iv[2] = 1'b0;
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_run_busy", 128'(bsy[2]), 128'(0));
    chk("clr_run_vld", 128'(ov[2]), 128'(0));
    chk("clr_run_dat", odat[2], '0);
    chk("clr_run_rdy", 128'(irdy[2]), 128'(1));
    for (int i = 0; i < 6; i++) step();
    chk("clr_run_novld", 128'(ov[2]), 128'(0));
    run_block(2, ALLFF, ALL7D, "after_clr_run");

    // Abort in DONE with out_ready high: result dropped.
    iv[2] = 1'b1; idat[2] = KIN; ordy[2] = 1'b0;
    step();
    iv[2] = 1'b0;
    wait_valid(2, n);
    chk("clr_done_vld_pre", 128'(ov[2]), 128'(1));
    clear = 1'b1; ordy[2] = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_done_busy", 128'(bsy[2]), 128'(0));
    chk("clr_done_vld", 128'(ov[2]), 128'(0));
    chk("clr_done_dat", odat[2], '0);
    chk("clr_done_rdy", 128'(irdy[2]), 128'(1));
    run_block(2, KIN, KOUT, "after_clr_done");

    // Reset mid-RUN, then reset together with clear.
    for (int j = 0; j < 2; j++) begin
      iv[2] = 1'b1; idat[2] = KIN;
      step();
      iv[2] = 1'b0;
      step();
      rst = 1'b1;
      clear = (j == 1);
      #1;
      chk($sformatf("mrst%0d_rdy_in", j), 128'(irdy[2]), 128'(0));
      step();
      chk($sformatf("mrst%0d_vld", j), 128'(ov[2]), 128'(0));
      chk($sformatf("mrst%0d_dat", j), odat[2], '0);
      chk($sformatf("mrst%0d_busy", j), 128'(bsy[2]), 128'(0));
      rst = 1'b0;
      clear = 1'b0;
      #1;
      chk($sformatf("mrst%0d_rdy_out", j), 128'(irdy[2]), 128'(1));
    end
    run_block(2, ALL63, '0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
